input_controller: RTL and testbench
===================================

// Module: input_controller
// PURPOSE
//  Upstream of grid_controller. Converts five raw, asynchronous, bouncing push-buttons into
//  single-cycle 4-bit command codes on controller_out. Each button path is synchronised and
//  debounced. Left/right/down auto-repeat while held. Commands are arbitrated one at a time,
//  with a mandatory idle gap between them so the grid FSM can sample each one.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive stable synced samples before a button changes state (>=1)
//  REPEAT_DELAY     50   cycles held after a press event before the first auto-repeat (>=1)
//  REPEAT_RATE      20   cycles between subsequent auto-repeats (>=1)
//  GAP_CYCLES       2    idle (4'b0000) cycles forced after every issued command (>=1)
//  (all counters 16 bit; every parameter must be < 65536)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high
//  btn_left        in   1  raw button, active-high, asynchronous
//  btn_right       in   1  raw button
//  btn_rotate      in   1  raw button
//  btn_down        in   1  raw button
//  btn_start       in   1  raw button
//  controller_out  out  4  command code, held for one cycle per command, else 4'b0000
//  btn_state       out  5  debounced levels {start,down,rotate,right,left} (debug/LEDs)
// BEHAVIOUR
//  Codes: 0000 none, 0001 LEFT, 0010 RIGHT, 0011 ROTATE, 0100 START, 0101 DOWN.
//  Reset: controller_out=0000; btn_state=0; sync flops, debounce/repeat counters, pending flags cleared.
//  Reset is a full reset at any time. An in-flight command or gap is abandoned.
//  A button still held when reset is released debounces afresh and produces one new press event.
//  Per button:
//   - Sync: 2-flop synchroniser (s1 -> s2).
//   - Debounce: counter increments each cycle while s2 != btn_state[k] and clears to 0 otherwise.
//     btn_state[k] toggles on the edge where the counter would reach DEBOUNCE_CYCLES; counter then clears.
//   - Press event: rising edge of btn_state[k] sets pending[k] on the following edge.
//     A release produces no event.
//   - Auto-repeat (left/right/down only): repeat counter starts at the press event.
//     The first repeat sets pending after REPEAT_DELAY cycles; later repeats follow every
//     REPEAT_RATE cycles while btn_state[k]=1.
//     Release clears the counter immediately. Rotate and start never repeat.
//   - An event on a button that is already pending merges; there is no queueing or counting.
//  Issue FSM:
//   - IDLE: when any pending bit is set, select by priority START > ROTATE > DOWN > LEFT > RIGHT.
//     Register its code into controller_out next edge, clear that pending bit, and go to ISSUE.
//   - ISSUE: one cycle with the code driven. Then controller_out=0000 and go to GAP.
//   - GAP: GAP_CYCLES cycles at 0000. Then IDLE.
//   - Pending flags keep collecting events during ISSUE and GAP.
//  Latency: clean raw press from IDLE to code on controller_out = DEBOUNCE_CYCLES+4 cycles.
//   Cycle 1 is the first edge sampling raw=1.
//  Bounce shorter than DEBOUNCE_CYCLES consecutive samples causes no state change and no event.
//  Simultaneous press events are issued in priority order, each separated by an ISSUE+GAP window.
//  Minimum command spacing = 1+GAP_CYCLES+1 cycles.
// TESTING
//  1. Defaults; raw left rises and stays high 5 cycles -> 0001 on controller_out exactly 1 cycle,
//     at edge 8; btn_state[0]=1.
//  2. btn_rotate toggles every 2 cycles for 20 cycles, then returns low
//     -> controller_out stays 0000 throughout; btn_state[2] stays 0.
//  3. Hold btn_down 200 cycles -> 0101 at press latency, then at +50, then every 20 cycles.
//     Stops within 1 repeat period of debounced release.
//  4. btn_start and btn_right rise on the same cycle
//     -> 0100, then 3 cycles of 0000, then 0010; no other codes.
//  5. Hold btn_rotate 300 cycles -> exactly one 0011.
//     Press left twice within one ISSUE+GAP window -> only one 0001 (merge).
//  6. Assert reset during ISSUE while left is still held -> controller_out=0000 next edge.
//     After reset drops: one new 0001 at DEBOUNCE_CYCLES+4, then repeats resume.

Source files
------------

// File: rtl/input_controller.sv
// input_controller: five raw push-buttons -> synchronised, debounced, auto-repeating
// single-cycle command codes, issued one at a time with an idle gap between them.

// One button path: 2-flop synchroniser, debounce counter, press detect, optional auto-repeat.
module input_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_RATE     = 20,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] DELAY_LAST = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] RATE_LAST  = 16'(REPEAT_RATE - 1);

   logic        s1, s2;
   logic [15:0] db_cnt;
   logic        level_d;
   logic [15:0] rep_cnt;
   logic        rep_first;
   logic        rise;
   logic        rep_hit;

   assign rise    = level & ~level_d;
   assign rep_hit = REPEAT_EN && level && !rise &&
                    (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST));
   // press is the event that sets the pending flag on the coming edge
   assign press   = rise | rep_hit;

   // two-flop synchroniser for the asynchronous raw input
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt <= '0;
         level  <= 1'b0;
      end else if (s2 != level) begin
         if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            level  <= ~level;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // delayed level for rising-edge detection
   always_ff @(posedge clk) begin
      if (reset) level_d <= 1'b0;
      else       level_d <= level;
   end

   // auto-repeat timer: restarts at the press event, first period long, then the rate
   always_ff @(posedge clk) begin
      if (reset || !REPEAT_EN || !level || rise) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_hit) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         rep_cnt   <= rep_cnt + 16'd1;
      end
   end
endmodule

// Top: per-button channels, pending flags, and the priority issue FSM.
module input_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_RATE     = 20,
   parameter int GAP_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       btn_down,
   input  logic       btn_start,
   output logic [3:0] controller_out,
   output logic [4:0] btn_state
);
   // bit order {start,down,rotate,right,left}; only left/right/down auto-repeat
   localparam logic [4:0]  REPEAT_MASK = 5'b01011;
   localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

   localparam logic [3:0] CODE_NONE   = 4'b0000;
   localparam logic [3:0] CODE_LEFT   = 4'b0001;
   localparam logic [3:0] CODE_RIGHT  = 4'b0010;
   localparam logic [3:0] CODE_ROTATE = 4'b0011;
   localparam logic [3:0] CODE_START  = 4'b0100;
   localparam logic [3:0] CODE_DOWN   = 4'b0101;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   logic [4:0]  raw;
   logic [4:0]  press;
   logic [4:0]  pending;
   logic [4:0]  clr;
   state_t      state, state_nxt;
   logic [3:0]  out_nxt;
   logic [15:0] gap_cnt, gap_nxt;

   assign raw = {btn_start, btn_down, btn_rotate, btn_right, btn_left};

   for (genvar i = 0; i < 5; i++) begin : g_ch
      input_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .REPEAT_EN      (REPEAT_MASK[i])
      ) u_ch (
         .clk  (clk),
         .reset(reset),
         .raw  (raw[i]),
         .level(btn_state[i]),
         .press(press[i])
      );
   end

   // pending flags: a new event wins over a same-cycle issue clear, repeats merge
   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr) | press;
   end

   // issue FSM state, output code and gap counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         controller_out <= CODE_NONE;
         gap_cnt        <= '0;
      end else begin
         state          <= state_nxt;
         controller_out <= out_nxt;
         gap_cnt        <= gap_nxt;
      end
   end

   // next-state: priority pick in IDLE, one-cycle ISSUE, then a counted idle GAP
   always_comb begin
      state_nxt = state;
      out_nxt   = CODE_NONE;
      gap_nxt   = gap_cnt;
      clr       = '0;
      case (state)
         IDLE: begin
            if (|pending) begin
               state_nxt = ISSUE;
               if (pending[4]) begin
                  out_nxt = CODE_START;  clr[4] = 1'b1;
               end else if (pending[2]) begin
                  out_nxt = CODE_ROTATE; clr[2] = 1'b1;
               end else if (pending[3]) begin
                  out_nxt = CODE_DOWN;   clr[3] = 1'b1;
               end else if (pending[0]) begin
                  out_nxt = CODE_LEFT;   clr[0] = 1'b1;
               end else begin
                  out_nxt = CODE_RIGHT;  clr[1] = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_nxt = GAP;
            gap_nxt   = '0;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            else                     gap_nxt   = gap_cnt + 16'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with default parameters.
// Edge k of a scenario is the k-th rising edge after its stimulus starts; outputs are
// sampled on the following falling edge.
module tb_input_controller;
   logic       clk = 1'b0;
   logic       reset;
   logic       btn_left, btn_right, btn_rotate, btn_down, btn_start;
   logic [3:0] controller_out;
   logic [4:0] btn_state;
   int         passed = 0;
   int         total  = 0;

   input_controller dut (
      .clk           (clk),
      .reset         (reset),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_rotate    (btn_rotate),
      .btn_down      (btn_down),
      .btn_start     (btn_start),
      .controller_out(controller_out),
      .btn_state     (btn_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_all();
      btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; btn_start = 0;
   endtask

   task automatic do_reset();
      release_all();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn_left = 1; btn_right = 1; btn_rotate = 1; btn_down = 1; btn_start = 1;
      repeat (4) tick();
      total++;
      if (controller_out !== 4'b0000) $display("FAIL reset_out got %b exp 0000", controller_out);
      else passed++;
      total++;
      if (btn_state !== 5'b00000) $display("FAIL reset_btn_state got %b exp 00000", btn_state);
      else passed++;
      do_reset();
   endtask

   task automatic test_latency();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         btn_left = (k <= 5);
         tick();
         exp = (k == 8) ? 4'b0001 : 4'b0000;
         total++;
         if (controller_out !== exp) $display("FAIL latency_out k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
         if (k == 5 || k == 6 || k == 10 || k == 12) begin
            total++;
            if (btn_state[0] !== (k == 6 || k == 10))
               $display("FAIL latency_level k=%0d got %b exp %b", k, btn_state[0], (k == 6 || k == 10));
            else passed++;
         end
      end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         btn_rotate = (k <= 20) && ((((k - 1) / 2) % 2) == 0);
         tick();
         total++;
         if (controller_out !== 4'b0000 || btn_state[2] !== 1'b0)
            $display("FAIL bounce k=%0d got out=%b lvl=%b exp out=0000 lvl=0", k, controller_out, btn_state[2]);
         else passed++;
      end
   endtask

   task automatic test_repeat();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 260; k++) begin
         btn_down = (k <= 200);
         tick();
         exp = (k == 8 || (k >= 58 && k <= 198 && ((k - 58) % 20) == 0)) ? 4'b0101 : 4'b0000;
         total++;
         if (controller_out !== exp) $display("FAIL repeat_down k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         btn_start = (k <= 10);
         btn_right = (k <= 10);
         tick();
         exp = (k == 8) ? 4'b0100 : (k == 12) ? 4'b0010 : 4'b0000;
         total++;
         if (controller_out !== exp) $display("FAIL back_to_back k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
      end
   endtask

   task automatic test_no_repeat_rotate();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 320; k++) begin
         btn_rotate = (k <= 300);
         tick();
         exp = (k == 8) ? 4'b0011 : 4'b0000;
         total++;
         if (controller_out !== exp) $display("FAIL rotate_hold k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
      end
   endtask

   // left pressed twice while its first event is still waiting behind higher priorities
   task automatic test_merge();
      logic [3:0] exp;
      do_reset();
      for (int k = 1; k <= 60; k++) begin
         btn_start  = (k <= 5);
         btn_rotate = (k <= 5);
         btn_down   = (k <= 5);
         btn_left   = (k <= 5) || (k >= 12 && k <= 17);
         tick();
         case (k)
            8:       exp = 4'b0100;
            12:      exp = 4'b0011;
            16:      exp = 4'b0101;
            20:      exp = 4'b0001;
            default: exp = 4'b0000;
         endcase
         total++;
         if (controller_out !== exp) $display("FAIL merge k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
      end
   endtask

   task automatic test_reset_in_issue();
      logic [3:0] exp;
      do_reset();
      btn_left = 1'b1;
      for (int k = 1; k <= 8; k++) tick();
      total++;
      if (controller_out !== 4'b0001) $display("FAIL rst_issue_pre got %b exp 0001", controller_out);
      else passed++;
      reset = 1'b1;
      tick();
      total++;
      if (controller_out !== 4'b0000 || btn_state !== 5'b00000)
         $display("FAIL rst_issue_abort got out=%b st=%b exp out=0000 st=00000", controller_out, btn_state);
      else passed++;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         exp = (k == 8 || k == 58 || k == 78 || k == 98) ? 4'b0001 : 4'b0000;
         total++;
         if (controller_out !== exp) $display("FAIL rst_issue_after k=%0d got %b exp %b", k, controller_out, exp);
         else passed++;
      end
      release_all();
      repeat (20) tick();
   endtask

   initial begin
      reset = 1'b1;
      release_all();
      @(negedge clk);
      test_reset();
      test_latency();
      test_bounce();
      test_repeat();
      test_back_to_back();
      test_no_repeat_rotate();
      test_merge();
      test_reset_in_issue();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
